// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset sequencer: hold all channels in reset, then release them one by one.
// Optional macro RESET_SEQUENCER_DEBOUNCE_EN adds a debounce filter on the synchronized request.
module reset_sequencer #(
    parameter int NCH         = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int DEB_CYCLES  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ext_rst_req,
    output logic [NCH-1:0] rst_out,
    output logic           seq_done
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int CW = $clog2(NCH + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);

    typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;

    state_t                state;
    logic [HW-1:0]         hold_cnt;
    logic [SW-1:0]         stg_cnt;
    logic [CW-1:0]         ch_cnt;
    logic [SYNC_DEPTH-1:0] sync;
    logic                  sync_out;
    logic                  sreq;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_DEPTH-2:0], ext_rst_req};
    end

    assign sync_out = sync[SYNC_DEPTH-1];

`ifdef RESET_SEQUENCER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_FULL = DW'(DEB_CYCLES);

    logic [DW-1:0] deb_cnt;

    // Counter saturates at DEB_CYCLES; any low cycle restarts the qualification window.
    always_ff @(posedge clk) begin
        if (reset || !sync_out)     deb_cnt <= '0;
        else if (deb_cnt != DEB_FULL) deb_cnt <= deb_cnt + 1'b1;
    end

    assign sreq = sync_out && (deb_cnt == DEB_FULL);
`else
    assign sreq = sync_out;
`endif

    always_ff @(posedge clk) begin
        if (reset || sreq) begin
            state    <= S_ASSERT;
            rst_out  <= '1;
            seq_done <= 1'b0;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            ch_cnt   <= '0;
        end else begin
            case (state)
                S_ASSERT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        rst_out <= rst_out << 1;
                        ch_cnt  <= ch_cnt + 1'b1;
                        // A single-channel build skips RELEASE entirely.
                        if (ch_cnt == CH_LAST) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (stg_cnt == STG_LAST) begin
                        stg_cnt <= '0;
                        rst_out <= rst_out << 1;
                        ch_cnt  <= ch_cnt + 1'b1;
                        if (ch_cnt == CH_LAST) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state    <= S_ASSERT;
                    rst_out  <= '1;
                    seq_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default 4-channel instance and a 1-channel instance
// share randomized stimulus and are compared each cycle against a quiet-time reference model.
module tb_reset_sequencer;

    localparam int P_N[2] = '{4, 1};
    localparam int P_S[2] = '{2, 3};
    localparam int P_H[2] = '{16, 1};
    localparam int P_T[2] = '{4, 1};
    localparam int P_D[2] = '{8, 3};
    localparam int Q_SAT  = 1000;

    typedef struct packed {
        logic [3:0] rst;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ext_rst_req = 1'b0;
    logic [3:0] rst0;
    logic       done0;
    logic [0:0] rst1;
    logic       done1;

    int n_total = 0;
    int n_pass  = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Model state: quiet-edge count, synchronizer history, consecutive-high run length.
    int          q[2];
    logic [15:0] hist[2];
    int          run[2];
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer dut0 (
        .clk(clk), .reset(reset), .ext_rst_req(ext_rst_req),
        .rst_out(rst0), .seq_done(done0)
    );

    reset_sequencer #(
        .NCH(1), .SYNC_DEPTH(3), .HOLD_CYCLES(1), .STAGGER(1), .DEB_CYCLES(3)
    ) dut1 (
        .clk(clk), .reset(reset), .ext_rst_req(ext_rst_req),
        .rst_out(rst1), .seq_done(done1)
    );

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at %0t: got rst=%h done=%b, expected rst=%h done=%b",
                      name, $time, act[4:1], act[0], expv[4:1], expv[0]);
    endtask

    // Reference: a channel is out of reset once enough consecutive quiet edges have elapsed.
    function automatic exp_t expect_of(input int d);
        exp_t e;
        e.rst = '0;
        for (int i = 0; i < P_N[d]; i++)
            e.rst[i] = (q[d] < P_H[d] + i * P_T[d]);
        e.done = (q[d] >= P_H[d] + (P_N[d] - 1) * P_T[d]);
        return e;
    endfunction

    function automatic bit sreq_of(input int d);
        bit so;
        so = hist[d][P_S[d]-1];
`ifdef RESET_SEQUENCER_DEBOUNCE_EN
        return so && (run[d] >= P_D[d]);
`else
        return so;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) model_valid = 1'b1;
        for (int d = 0; d < 2; d++) begin
            bit req_before;
            bit so_before;
            req_before = sreq_of(d);
            so_before  = hist[d][P_S[d]-1];
            if (reset || req_before) q[d] = 0;
            else if (q[d] < Q_SAT)    q[d] = q[d] + 1;
            if (reset) begin
                hist[d] = '0;
                run[d]  = 0;
            end else begin
                hist[d] = {hist[d][14:0], ext_rst_req};
                run[d]  = so_before ? ((run[d] < P_D[d]) ? run[d] + 1 : run[d]) : 0;
            end
            if (model_valid) begin
                if (d == 0) exp_q0.push_back(expect_of(0));
                else        exp_q1.push_back(expect_of(1));
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("dut0_out", {rst0, done0}, {e.rst, e.done});
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("dut1_out", {3'b000, rst1, done1}, {e.rst, e.done});
        end
    end

    task automatic drive(input int n, input logic r, input logic e);
        repeat (n) begin
            @(negedge clk);
            reset       = r;
            ext_rst_req = e;
        end
    endtask

    initial begin
        int      waited;
        int unsigned sel;
        // Reset for 3 cycles, then let the full default sequence complete.
        drive(3, 1'b1, 1'b0);
        drive(40, 1'b0, 1'b0);
        // One-cycle request while running.
        drive(1, 1'b0, 1'b1);
        drive(45, 1'b0, 1'b0);
        // Request while the default instance is mid-release at 4'b1100.
        drive(3, 1'b1, 1'b0);
        waited = 0;
        while (rst0 !== 4'b1100 && waited < 100) begin
            drive(1, 1'b0, 1'b0);
            waited++;
        end
        if (waited >= 100) begin
            n_total++;
            $display("FAIL wait_1100: rst_out never reached 4'b1100 (last %h)", rst0);
        end
        drive(4, 1'b0, 1'b1);
        drive(45, 1'b0, 1'b0);
        // Reset and request together, request outlives reset.
        drive(3, 1'b1, 1'b1);
        drive(6, 1'b0, 1'b1);
        drive(45, 1'b0, 1'b0);
        // Debounce-length pulses: short, then long.
        drive(5, 1'b0, 1'b1);
        drive(20, 1'b0, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(45, 1'b0, 1'b0);
        // Randomized mix of quiet stretches, request pulses and resets.
        repeat (150) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: drive($urandom_range(1, 45), 1'b0, 1'b0);
                1: begin
                    drive($urandom_range(1, 12), 1'b0, 1'b1);
                    drive($urandom_range(1, 35), 1'b0, 1'b0);
                end
                2: drive($urandom_range(1, 3), 1'b1, 1'b0);
                default: begin
                    drive($urandom_range(1, 3), 1'b1, 1'b1);
                    drive($urandom_range(0, 6), 1'b0, 1'b1);
                end
            endcase
        end
        drive(40, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
